// File: rtl/div_pkg.sv
// Shared definitions for the quotient rounding pipeline.
// Holds widths, rounding modes, flag indices and the result bundle.
package div_pkg;

    localparam int QW     = 40;
    localparam int INT_W  = 32;
    localparam int FRAC_W = 8;
    localparam int FLAG_W = 3;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'b00,
        RND_HALF_UP   = 2'b01,
        RND_HALF_EVEN = 2'b10
    } rnd_mode_e;

    localparam int FLG_INEXACT = 0;
    localparam int FLG_SAT     = 1;
    localparam int FLG_DZ      = 2;

    localparam logic [INT_W-1:0] SAT_VAL = '1;

    typedef struct packed {
        logic [INT_W-1:0]  data;
        logic [FLAG_W-1:0] flags;
    } rnd_res_t;

    // Raw mode bits to a rounding mode; the unused code rounds as truncate.
    function automatic rnd_mode_e to_mode(input logic [1:0] m);
        rnd_mode_e r;
        case (m)
            2'b01:   r = RND_HALF_UP;
            2'b10:   r = RND_HALF_EVEN;
            default: r = RND_TRUNC;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/round_unit.sv
// Combinational rounding of a fixed-point quotient to an integer.
// Applies the rounding increment, saturates on carry out, reports flags.
module round_unit #(
    parameter int QW = 40
) (
    input  logic [QW-1:0]       q_i,
    input  logic                dz_i,
    input  div_pkg::rnd_mode_e  mode_i,
    output div_pkg::rnd_res_t   res_o
);
    import div_pkg::*;

    localparam logic [FRAC_W-1:0] HALF = {1'b1, {(FRAC_W-1){1'b0}}};

    logic [INT_W-1:0]  ipart;
    logic [FRAC_W-1:0] fpart;
    logic              inc;
    logic [INT_W:0]    sum;

    assign ipart = q_i[FRAC_W +: INT_W];
    assign fpart = q_i[FRAC_W-1:0];

    // Rounding increment chosen by the captured mode.
    always_comb begin
        inc = 1'b0;
        case (mode_i)
            RND_HALF_UP:   inc = fpart[FRAC_W-1];
            RND_HALF_EVEN: inc = (fpart > HALF) ||
                                 ((fpart == HALF) && ipart[0]);
            default:       inc = 1'b0;
        endcase
    end

    assign sum = {1'b0, ipart} + {{INT_W{1'b0}}, inc};

    // Final value and flags; divide by zero overrides all rounding.
    always_comb begin
        res_o = '0;
        if (dz_i) begin
            res_o.data          = SAT_VAL;
            res_o.flags[FLG_DZ] = 1'b1;
        end else begin
            res_o.flags[FLG_INEXACT] = (fpart != '0);
            if (sum[INT_W]) begin
                res_o.data           = SAT_VAL;
                res_o.flags[FLG_SAT] = 1'b1;
            end else begin
                res_o.data = sum[INT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/quotient_rounder.sv
// Two-stage valid/ready pipeline rounding divider quotients.
// S1 captures the raw quotient, S2 holds the rounded result and flags.
module quotient_rounder #(
    parameter int QW = 40,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] in_q,
    input  logic          in_dz,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [2:0]    out_flags,
    output logic [CW-1:0] dz_cnt,
    output logic [CW-1:0] sat_cnt
);
    import div_pkg::*;

    logic          s1_valid_q, s1_valid_d;
    logic [QW-1:0] s1_q_q, s1_q_d;
    logic          s1_dz_q, s1_dz_d;
    rnd_mode_e     s1_mode_q, s1_mode_d;

    logic          s2_valid_q, s2_valid_d;
    rnd_res_t      s2_res_q, s2_res_d;

    logic [CW-1:0] dz_cnt_q, dz_cnt_d;
    logic [CW-1:0] sat_cnt_q, sat_cnt_d;

    rnd_res_t      rnd_res;
    logic          s1_adv;
    logic          in_fire;
    logic          out_fire;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    round_unit #(
        .QW(QW)
    ) u_round (
        .q_i    (s1_q_q),
        .dz_i   (s1_dz_q),
        .mode_i (s1_mode_q),
        .res_o  (rnd_res)
    );

    // S1 next state: load on input transfer, empty when handed to S2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_q_d     = s1_q_q;
        s1_dz_d    = s1_dz_q;
        s1_mode_d  = s1_mode_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_q_d     = in_q;
            s1_dz_d    = in_dz;
            s1_mode_d  = to_mode(mode);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state: refill from S1 whenever the output slot frees up.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = rnd_res;
            end
        end
    end

    // Event counters count delivered results and stick at all ones.
    always_comb begin
        dz_cnt_d  = dz_cnt_q;
        sat_cnt_d = sat_cnt_q;
        if (out_fire && s2_res_q.flags[FLG_DZ] && (dz_cnt_q != '1)) begin
            dz_cnt_d = dz_cnt_q + 1'b1;
        end
        if (out_fire && s2_res_q.flags[FLG_SAT] && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q_q     <= '0;
            s1_dz_q    <= 1'b0;
            s1_mode_q  <= RND_TRUNC;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q_q     <= s1_q_d;
            s1_dz_q    <= s1_dz_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_cnt_q  <= '0;
            sat_cnt_q <= '0;
        end else begin
            dz_cnt_q  <= dz_cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_res_q.data;
    assign out_flags = s2_res_q.flags;
    assign dz_cnt    = dz_cnt_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_quotient_rounder.sv
// Self-checking bench for quotient_rounder: table vectors, scoreboard
// against an arithmetic model, backpressure, reset and random traffic.
module tb_quotient_rounder;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [39:0]   in_q = '0;
    logic          in_dz = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [2:0]    out_flags;
    logic [CW-1:0] dz_cnt;
    logic [CW-1:0] sat_cnt;

    int total = 0;
    int bad   = 0;

    quotient_rounder #(.QW(40), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_dz     (in_dz),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .dz_cnt    (dz_cnt),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the quotient fields.
    function automatic logic [34:0] model(input logic [39:0] q,
                                          input logic dz,
                                          input logic [1:0] m);
        longint unsigned i;
        longint unsigned r;
        int unsigned f;
        logic inexact;
        i = longint'(q[39:8]);
        f = int'(q[7:0]);
        inexact = (f != 0);
        if (dz) return {3'b100, 32'hFFFF_FFFF};
        if (m == 2'd1)
            r = i + ((f >= 128) ? 1 : 0);
        else if (m == 2'd2)
            r = i + (((f > 128) || (f == 128 && (i % 2) == 1)) ? 1 : 0);
        else
            r = i;
        if (r > 64'hFFFF_FFFF) return {1'b0, 1'b1, inexact, 32'hFFFF_FFFF};
        return {1'b0, 1'b0, inexact, r[31:0]};
    endfunction

    logic [34:0] sb[$];
    int          m_dz = 0;
    int          m_sat = 0;
    int          n_rx = 0;
    logic        held = 1'b0;
    logic [34:0] held_v;
    localparam int CMAX = (1 << CW) - 1;

    // Scoreboard and counter/stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_dz = 0;
            m_sat = 0;
            held = 1'b0;
        end else begin
            chk("dz_cnt", 64'(dz_cnt), 64'(m_dz));
            chk("sat_cnt", 64'(sat_cnt), 64'(m_sat));
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({out_flags, out_data}), 64'(held_v));
            end
            if (out_valid && out_ready) begin
                n_rx++;
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'({out_flags, out_data}), 64'h7FFFFFFFFF);
                end else begin
                    chk("sb_result", 64'({out_flags, out_data}),
                        64'(sb.pop_front()));
                end
                if (out_flags[2] && m_dz < CMAX) m_dz++;
                if (out_flags[1] && m_sat < CMAX) m_sat++;
            end
            held = out_valid && !out_ready;
            held_v = {out_flags, out_data};
            if (in_valid && in_ready) sb.push_back(model(in_q, in_dz, mode));
        end
    end

    task automatic send(input logic [39:0] q, input logic dz,
                        input logic [1:0] m);
        int n = 0;
        logic ok;
        in_q = q;
        in_dz = dz;
        mode = m;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (lat > 30) begin
                chk("out_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [39:0] q;
        logic        dz;
        logic [1:0]  m;
        logic [31:0] data;
        logic [2:0]  flags;
    } vec_t;

    vec_t vt[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rx0;
        logic saw_low;
        logic done;

        vt[0]  = '{40'h00000005_80, 1'b0, 2'b10, 32'd6, 3'b001};
        vt[1]  = '{40'h00000005_80, 1'b0, 2'b00, 32'd5, 3'b001};
        vt[2]  = '{40'h00000004_80, 1'b0, 2'b10, 32'd4, 3'b001};
        vt[3]  = '{40'h00000004_80, 1'b0, 2'b01, 32'd5, 3'b001};
        vt[4]  = '{40'h00000007_00, 1'b0, 2'b00, 32'd7, 3'b000};
        vt[5]  = '{40'h00000007_00, 1'b0, 2'b01, 32'd7, 3'b000};
        vt[6]  = '{40'h00000007_00, 1'b0, 2'b10, 32'd7, 3'b000};
        vt[7]  = '{40'h00000007_00, 1'b0, 2'b11, 32'd7, 3'b000};
        vt[8]  = '{40'hFFFFFFFF_C0, 1'b0, 2'b01, 32'hFFFFFFFF, 3'b011};
        vt[9]  = '{40'h12345678_9A, 1'b1, 2'b01, 32'hFFFFFFFF, 3'b100};
        vt[10] = '{40'h00000005_81, 1'b0, 2'b11, 32'd5, 3'b001};
        vt[11] = '{40'hFFFFFFFF_80, 1'b0, 2'b10, 32'hFFFFFFFF, 3'b011};
        vt[12] = '{40'hFFFFFFFE_80, 1'b0, 2'b10, 32'hFFFFFFFE, 3'b001};
        vt[13] = '{40'h00000003_81, 1'b0, 2'b10, 32'd4, 3'b001};
        vt[14] = '{40'hFFFFFFFF_7F, 1'b0, 2'b01, 32'hFFFFFFFF, 3'b001};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Table vectors; mode is scrambled right after acceptance.
        for (int i = 0; i < 15; i++) begin
            send(vt[i].q, vt[i].dz, vt[i].m);
            in_valid = 1'b0;
            mode = ~vt[i].m;
            wait_out(lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd2);
            chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(vt[i].data));
            chk($sformatf("tbl%0d_flags", i), 64'(out_flags), 64'(vt[i].flags));
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: 8 back-to-back with a 5-cycle output stall.
        rx0 = n_rx;
        saw_low = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send({$urandom, 8'($urandom)}, 1'b0, 2'($urandom_range(0, 2)));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_low", 64'(saw_low), 64'd1);
        chk("bp_count", 64'(n_rx - rx0), 64'd8);

        // Random traffic with random gaps and backpressure.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [31:0] iv;
                    logic [7:0]  fv;
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 3))
                        0: iv = 32'hFFFFFFFF;
                        1: iv = 32'($urandom_range(0, 9));
                        default: iv = $urandom;
                    endcase
                    case ($urandom_range(0, 3))
                        0: fv = 8'h80;
                        1: fv = 8'h00;
                        default: fv = 8'($urandom);
                    endcase
                    send({iv, fv}, ($urandom_range(0, 7) == 0),
                         2'($urandom));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("dz_cnt_sat", 64'(dz_cnt), 64'(CMAX));

        // Reset with both stages full.
        out_ready = 1'b0;
        send(40'h00000002_40, 1'b0, 2'b00);
        send(40'h00000003_40, 1'b1, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_dz_cnt", 64'(dz_cnt), 64'd0);
        chk("arst_sat_cnt", 64'(sat_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_data", 64'(out_data), 64'd0);
        chk("post_rst_flags", 64'(out_flags), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rx0 = n_rx;
        send(40'h00000009_C0, 1'b0, 2'b01);
        in_valid = 1'b0;
        wait_out(lat);
        chk("post_rst_lat", 64'(lat), 64'd2);
        chk("post_rst_res", 64'(out_data), 64'd10);
        chk("post_rst_fl", 64'(out_flags), 64'b001);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_count", 64'(n_rx - rx0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quotient_rounder.md
QUOTIENT_ROUNDER -- requirements
Module: quotient_rounder

Interface
REQ-001 Parameter QW, default 40, is the input quotient width: Q32.8 unsigned, 32 integer and 8 fraction bits.
REQ-002 Parameter CW, default 16, is the width of the event counters.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream divider result present.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 in_q  input  QW  quotient from the combinational divider, q[39:8] integer, q[7:0] fraction.
REQ-008 in_dz  input  1  divisor was zero, supplied by upstream alongside in_q.
REQ-009 mode  input  2  rounding mode: 00 truncate, 01 round-half-up, 10 round-half-even, 11 treated as truncate.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  32  rounded integer quotient.
REQ-013 out_flags  output  3  {dz, sat, inexact}.
REQ-014 dz_cnt, sat_cnt  output  CW each  saturating event counters.

Function
REQ-015 Transfer: a transfer occurs on each port when valid and ready are both high at a clock edge; no other condition causes a transfer.
REQ-016 Pipeline: two registered stages.
- S1 captures in_q, in_dz and mode on input transfer.
- S2 holds the rounded result, driven directly onto the out_* ports.
REQ-017 Latency: 2 cycles from input transfer to out_valid when out_ready stays high; throughput 1 result per cycle.
REQ-018 Ready logic: in_ready = !s1_valid || (S1 advances this cycle); S1 advances when !s2_valid || out_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 Output stability: while out_valid is high and out_ready is low, out_data and out_flags SHALL stay constant.
REQ-020 Mode sampling: mode is sampled only at input transfer; a mode change while data is in flight SHALL NOT affect that data.
REQ-021 Rounding: with I = q[39:8] and F = q[7:0]:
- truncate gives I;
- half-up gives I + F[7];
- half-even gives I + (F > 0x80 || (F == 0x80 && I[0])).
REQ-022 Saturation: the addition is computed in 33 bits; a carry out SHALL force out_data = 0xFFFFFFFF and set sat.
REQ-023 Inexact: inexact = (F != 0), independent of mode.
REQ-024 Divide by zero: when in_dz is set, out_data = 0xFFFFFFFF, flags = 3'b100, and rounding is bypassed.
REQ-025 Counters: dz_cnt and sat_cnt increment by one on each output transfer carrying the respective flag and SHALL hold at all ones.
REQ-026 Simultaneous events: a simultaneous input transfer and output transfer SHALL lose no data and duplicate none.

Reset
REQ-027 Asserting rst SHALL immediately clear s1_valid, s2_valid and both counters; out_valid is 0, out_data is 0, out_flags is 0, and in_ready is 1 in the first cycle after deassertion.
REQ-028 Data in flight at reset SHALL be discarded; no partial result appears after reset.

Structure
REQ-029 A shared package div_pkg SHALL hold:
- QW, INT_W (32) and FRAC_W (8);
- the rounding mode enum (RND_TRUNC, RND_HALF_UP, RND_HALF_EVEN);
- the flag bit indices.
REQ-030 The rounding and saturation arithmetic SHALL be one combinational sub-module, round_unit, instantiated between S1 and S2; everything else lives in quotient_rounder.

Verification
REQ-031 in_q = 0x00000005_80 with mode 10 -> out_data 6, flags 001; same input with mode 00 -> out_data 5, flags 001.
REQ-032 in_q = 0x00000004_80 with mode 10 -> out_data 4; with mode 01 -> out_data 5; in_q = 0x00000007_00 in any mode -> out_data 7, flags 000.
REQ-033 in_q = 0xFFFFFFFF_C0 with mode 01 -> out_data 0xFFFFFFFF, flags 011, sat_cnt incremented by 1.
REQ-034 in_dz = 1 with arbitrary in_q -> out_data 0xFFFFFFFF, flags 100, dz_cnt incremented.
REQ-035 Backpressure: stream 8 results with out_ready held low for 5 cycles mid-stream -> in_ready drops, output is held stable, and all 8 results arrive in order with none lost or duplicated.
REQ-036 Reset mid-operation: assert rst with both stages full -> out_valid 0 and counters 0; the next accepted input emerges exactly 2 cycles after acceptance.
